// File: rtl/uart_phy_fifo_pkg.sv
// UART PHY shared types: FSM state encoding, frame constants
// and the clocks-per-bit helper.
package UartPhyStruct;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } PhyState;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  function automatic int calc_div(
    input int clk_freq,
    input int baud
  );
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_phy_fifo_if.sv
// Byte-level handshake between the UART MMIO slave (master)
// and the serial PHY (slave).
interface uart_phy_fifo_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_overrun_clr;
  logic       tx_busy;

  modport master (
    output tx_data, tx_valid,
    output rx_ready, rx_overrun_clr,
    input  tx_ready, tx_busy,
    input  rx_data, rx_valid,
    input  rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid,
    input  rx_ready, rx_overrun_clr,
    output tx_ready, tx_busy,
    output rx_data, rx_valid,
    output rx_frame_err, rx_overrun
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers wrap naturally, occupancy is
// tracked by an explicit count so full/empty are unambiguous.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_phy_fifo.sv
// 8N1 serial engine: FIFO-buffered transmitter and a
// double-synchronised receiver with a one-byte holding register.
module uart_phy_fifo
  import UartPhyStruct::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rstn,
  uart_phy_fifo_if.slave  bus,
  output logic            txd,
  input  logic            rxd
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [2:0]    BLST = 3'(DATA_BITS - 1);

  logic [7:0]     w_head;
  logic           w_full;
  logic           w_empty;
  logic [FCW-1:0] w_count;
  logic           w_pop;
  logic           w_tx_wrap;

  PhyState    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic       r_txd;
  logic       r_tx_busy;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (bus.tx_valid),
    .i_data  (bus.tx_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_tx_wrap = (r_tx_cnt == LAST);
  assign w_pop = !w_empty && ((r_tx_state == IDLE) ||
                 (r_tx_state == STOP && w_tx_wrap));
  assign bus.tx_ready = !w_full;
  assign bus.tx_busy  = r_tx_busy;
  assign txd          = r_txd;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_busy <= (w_count != '0) || (r_tx_state != IDLE);
      unique case (r_tx_state)
        IDLE: begin
          r_txd    <= 1'b1;
          r_tx_cnt <= '0;
          if (!w_empty) begin
            r_tx_shift <= w_head;
            r_tx_state <= START;
          end
        end
        START: begin
          r_txd    <= 1'b0;
          r_tx_cnt <= w_tx_wrap ? '0 : r_tx_cnt + 1'b1;
          if (w_tx_wrap) begin
            r_tx_bit   <= '0;
            r_tx_state <= DATA;
          end
        end
        DATA: begin
          r_txd    <= r_tx_shift[0];
          r_tx_cnt <= w_tx_wrap ? '0 : r_tx_cnt + 1'b1;
          if (w_tx_wrap) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 1'b1;
            if (r_tx_bit == BLST) r_tx_state <= STOP;
          end
        end
        STOP: begin
          r_txd    <= 1'b1;
          r_tx_cnt <= w_tx_wrap ? '0 : r_tx_cnt + 1'b1;
          if (w_tx_wrap) begin
            // Chain straight into the next start bit when data waits
            if (!w_empty) begin
              r_tx_shift <= w_head;
              r_tx_state <= START;
            end else begin
              r_tx_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  PhyState    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_fe;
  logic       r_rx_ovr;
  logic       r_rxd_m;
  logic       r_rxd_s;
  logic       r_rx_armed;
  logic       w_rx_end;
  logic       w_rx_good;
  logic       w_rx_bad;

  assign w_rx_end  = (r_rx_state == STOP) && (r_rx_cnt == LAST);
  assign w_rx_good = w_rx_end && r_rxd_s;
  assign w_rx_bad  = w_rx_end && !r_rxd_s;

  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_frame_err = r_rx_fe;
  assign bus.rx_overrun   = r_rx_ovr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rxd_m    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rx_armed <= 1'b1;
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_fe    <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rxd_m <= rxd;
      r_rxd_s <= r_rxd_m;
      r_rx_fe <= w_rx_bad;
      if (r_rxd_s) r_rx_armed <= 1'b1;

      unique case (1'b1)
        w_rx_good && (!r_rx_valid || bus.rx_ready): begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end
        r_rx_valid && bus.rx_ready:
          r_rx_valid <= 1'b0;
        default: ;
      endcase

      if (w_rx_good && r_rx_valid && !bus.rx_ready)
        r_rx_ovr <= 1'b1;
      else if (bus.rx_overrun_clr)
        r_rx_ovr <= 1'b0;

      unique case (r_rx_state)
        IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rxd_s && r_rx_armed) r_rx_state <= START;
        end
        START: begin
          if (r_rx_cnt == HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rxd_s ? IDLE : DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        DATA: begin
          r_rx_cnt <= (r_rx_cnt == LAST) ? '0 : r_rx_cnt + 1'b1;
          if (r_rx_cnt == LAST) begin
            r_rx_shift <= {r_rxd_s, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == BLST) r_rx_state <= STOP;
          end
        end
        STOP: begin
          r_rx_cnt <= (r_rx_cnt == LAST) ? '0 : r_rx_cnt + 1'b1;
          if (w_rx_end) begin
            r_rx_state <= IDLE;
            // A low stop bit must be seen high before re-arming
            if (!r_rxd_s) r_rx_armed <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy_fifo.sv
// Directed bench for uart_phy_fifo with TX/RX byte scoreboards
// and a serial-line monitor on txd.
module tb_uart_phy_fifo;
  import UartPhyStruct::*;

  localparam int CF  = 16;
  localparam int BD  = 1;
  localparam int FD  = 4;
  localparam int DIV = calc_div(CF, BD);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rxd  = 1'b1;
  logic txd;

  uart_phy_fifo_if bus ();

  uart_phy_fifo #(
    .CLK_FREQ   (CF),
    .BAUD       (BD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .txd  (txd),
    .rxd  (rxd)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         fe_cnt   = 0;
  bit         mon_abort = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  time        starts[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (bus.rx_frame_err === 1'b1) fe_cnt++;

  // txd monitor: decode each frame at mid-bit and score it
  initial begin
    logic       prev;
    logic       sb;
    logic       stp;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0 && rstn === 1'b1) begin
        starts.push_back($time);
        repeat (DIV / 2) @(negedge clk);
        sb = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        stp = txd;
        if (!mon_abort) begin
          chk("tx_start_bit", sb, 0);
          chk("tx_stop_bit", stp, 1);
          chk("tx_exp_avail", tx_exp.size() > 0, 1);
          if (tx_exp.size() > 0)
            chk("tx_byte", b, tx_exp.pop_front());
        end
      end
      prev = txd;
    end
  end

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic rx_expect(input string tag);
    int n;
    n = 0;
    while (bus.rx_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.rx_valid, 1);
    chk({tag, "_exp_avail"}, rx_exp.size() > 0, 1);
    if (rx_exp.size() > 0)
      chk({tag, "_data"}, bus.rx_data, rx_exp.pop_front());
  endtask

  task automatic rx_pop(input string tag);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    chk(tag, bus.rx_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t2 [8];
    int   idx;
    int   n;
    int   f0;
    int   lows;
    logic rdy;

    t2 = '{8'h01, 8'h82, 8'hC3, 8'h24, 8'hE5, 8'h66, 8'h77, 8'h88};
    bus.tx_data        = '0;
    bus.tx_valid       = 1'b0;
    bus.rx_ready       = 1'b0;
    bus.rx_overrun_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_frame_err", bus.rx_frame_err, 0);
    chk("rst_overrun", bus.rx_overrun, 0);
    chk("rst_tx_busy", bus.tx_busy, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: latency, start width, busy drop
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    tx_exp.push_back(8'h55);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("tx1_k0_idle", txd, 1);
    @(negedge clk);
    chk("tx1_k1_idle", txd, 1);
    @(negedge clk);
    chk("tx1_k2_start", txd, 0);
    repeat (15) @(negedge clk);
    chk("tx1_k17_start", txd, 0);
    @(negedge clk);
    chk("tx1_k18_bit0", txd, 1);
    repeat (143) @(negedge clk);
    chk("tx1_k161_busy", bus.tx_busy, 1);
    @(negedge clk);
    chk("tx1_k162_idle", bus.tx_busy, 0);
    repeat (4) @(negedge clk);

    // Burst of 8 held valid: only 5 fit, frames back-to-back
    starts.delete();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 8) begin
        bus.tx_data  = t2[idx];
        bus.tx_valid = 1'b1;
      end else begin
        bus.tx_valid = 1'b0;
      end
      rdy = bus.tx_ready;
      @(posedge clk);
      if (rdy && bus.tx_valid) begin
        tx_exp.push_back(t2[idx]);
        idx++;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    chk("tx2_accepted", idx, 5);
    chk("tx2_full_ready", bus.tx_ready, 0);
    n = 0;
    while (bus.tx_busy === 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("tx2_drain", bus.tx_busy, 0);
    repeat (4) @(negedge clk);
    chk("tx2_ready_again", bus.tx_ready, 1);
    chk("tx2_frames", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      chk("tx2_pitch", int'((starts[i] - starts[i-1]) / 10),
          FRAME_BITS * DIV);
    chk("tx2_sb_empty", tx_exp.size(), 0);

    // Good RX frame
    f0 = fe_cnt;
    rx_exp.push_back(8'hA3);
    rx_frame(8'hA3, 1'b1);
    rx_expect("rx3");
    chk("rx3_no_ferr", fe_cnt - f0, 0);
    rx_pop("rx3_popped");

    // Start-bit glitch, then a clean frame still decodes
    f0 = fe_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("rx4_no_valid", bus.rx_valid, 0);
    chk("rx4_no_ferr", fe_cnt - f0, 0);
    rx_exp.push_back(8'h5A);
    rx_frame(8'h5A, 1'b1);
    rx_expect("rx4_after");
    rx_pop("rx4_popped");

    // Framing error
    f0 = fe_cnt;
    rx_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("rx5_ferr_pulses", fe_cnt - f0, 1);
    chk("rx5_no_valid", bus.rx_valid, 0);

    // Overrun: second byte dropped, first kept
    rx_exp.push_back(8'h11);
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    repeat (8) @(negedge clk);
    chk("rx6_overrun", bus.rx_overrun, 1);
    rx_expect("rx6_kept");
    @(negedge clk);
    bus.rx_overrun_clr = 1'b1;
    @(negedge clk);
    bus.rx_overrun_clr = 1'b0;
    chk("rx6_ovr_clr", bus.rx_overrun, 0);
    rx_pop("rx6_popped");
    chk("rx6_sb_empty", rx_exp.size(), 0);

    // Reset mid-frame with two bytes queued
    mon_abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tx_data  = 8'hF0 + 8'(i);
      bus.tx_valid = 1'b1;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst7_mid_busy", bus.tx_busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst7_txd", txd, 1);
    chk("rst7_busy", bus.tx_busy, 0);
    chk("rst7_ready", bus.tx_ready, 1);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("rst7_no_frames", lows, 0);
    chk("rst7_still_idle", bus.tx_busy, 0);
    mon_abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
